// File: rtl/result_display.sv
// Latches a signed-magnitude result plus status flags and scans it onto a
// 4-digit common-anode seven-segment display, blinking "Err" on divide-by-zero.
module result_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [4:0] result_in,
   input  logic       divbyzero_in,
   input  logic       zero_in,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       err_active
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_R     = 7'b0101111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic          sign_q, sign_d;
   logic [1:0]    mag_q, mag_d;
   logic          err_q, err_d;
   logic          zero_q, zero_d;
   logic [1:0]    idx_q, idx_d;
   logic [RW-1:0] ref_cnt_q, ref_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;
   logic          show_minus;
   logic [6:0]    mag_seg;

   // Bits 3:2 of the result carry no meaning for this display.
   logic unused_result_bits;
   assign unused_result_bits = ^result_in[3:2];

   always_comb begin
      sign_d      = sign_q;
      mag_d       = mag_q;
      err_d       = err_q;
      zero_d      = zero_q;
      idx_d       = idx_q;
      ref_cnt_d   = ref_cnt_q + 1'b1;
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;

      if (load) begin
         sign_d = result_in[4];
         mag_d  = result_in[1:0];
         err_d  = divbyzero_in;
         zero_d = zero_in;
      end

      // The scan free-runs; a load never disturbs the digit position.
      if (ref_cnt_q == REF_MAX) begin
         ref_cnt_d = '0;
         idx_d     = idx_q + 2'd1;
      end

      // Any load restarts the blink visible, so a fresh error shows at once.
      if (load || !err_q) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (blink_cnt_q == BLINK_MAX) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end

      case (mag_q)
         2'd0:    mag_seg = SEG_0;
         2'd1:    mag_seg = SEG_1;
         2'd2:    mag_seg = SEG_2;
         default: mag_seg = SEG_3;
      endcase

      // Negative zero is shown as a plain "0".
      show_minus = sign_q && (mag_q != 2'd0) && !zero_q;

      case (idx_q)
         2'd3:    seg_d = err_q ? SEG_E : (show_minus ? SEG_MINUS : SEG_BLANK);
         2'd2:    seg_d = err_q ? SEG_R : SEG_BLANK;
         2'd1:    seg_d = err_q ? SEG_R : SEG_BLANK;
         default: seg_d = err_q ? SEG_BLANK : mag_seg;
      endcase

      an_d = phase_q ? ~(4'b0001 << idx_q) : 4'hF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q      <= 1'b0;
         mag_q       <= 2'd0;
         err_q       <= 1'b0;
         zero_q      <= 1'b1;
         idx_q       <= 2'd0;
         ref_cnt_q   <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
         seg_q       <= 7'h7F;
         an_q        <= 4'hF;
      end else begin
         sign_q      <= sign_d;
         mag_q       <= mag_d;
         err_q       <= err_d;
         zero_q      <= zero_d;
         idx_q       <= idx_d;
         ref_cnt_q   <= ref_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign err_active = err_q;

endmodule

// File: tb/tb_result_display.sv
// Randomized bench for result_display, checked every cycle against a
// character-level model of what the display should show.
module tb_result_display;

   localparam int REFRESH_DIV = 4;
   localparam int BLINK_DIV   = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [4:0] result_in = 5'd0;
   logic       divbyzero_in = 1'b0;
   logic       zero_in = 1'b0;
   logic [6:0] seg;
   logic [3:0] an;
   logic       err_active;

   int vectors = 0;
   int miscompares = 0;

   // model state
   int   m_sign, m_mag, m_err, m_zero;
   int   m_idx, m_rc, m_bc, m_phase;
   logic [6:0] exp_seg;
   logic [3:0] exp_an;

   result_display #(.REFRESH_DIV(REFRESH_DIV), .BLINK_DIV(BLINK_DIV)) dut (
      .clk(clk), .rst(rst), .load(load), .result_in(result_in),
      .divbyzero_in(divbyzero_in), .zero_in(zero_in),
      .seg(seg), .an(an), .err_active(err_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic byte char_at(input int pos);
      if (m_err != 0) begin
         case (pos)
            3: return "E";
            2: return "r";
            1: return "r";
            default: return " ";
         endcase
      end
      if (pos == 3) return (m_sign != 0 && m_mag != 0 && m_zero == 0) ? "-" : " ";
      if (pos == 0) return byte'("0" + m_mag);
      return " ";
   endfunction

   function automatic logic [6:0] glyph(input byte c);
      case (c)
         "0": return 7'b1000000;
         "1": return 7'b1111001;
         "2": return 7'b0100100;
         "3": return 7'b0110000;
         "-": return 7'b0111111;
         "E": return 7'b0000110;
         "r": return 7'b0101111;
         default: return 7'b1111111;
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs presented to it.
   task automatic model_edge();
      if (rst) begin
         exp_seg = 7'h7F; exp_an = 4'hF;
         m_sign = 0; m_mag = 0; m_err = 0; m_zero = 1;
         m_idx = 0; m_rc = 0; m_bc = 0; m_phase = 1;
         return;
      end
      exp_seg = glyph(char_at(m_idx));
      exp_an  = (m_phase != 0) ? 4'(~(1 << m_idx)) : 4'hF;
      if (m_rc == REFRESH_DIV - 1) begin
         m_rc = 0;
         m_idx = (m_idx + 1) % 4;
      end else m_rc++;
      if (load || m_err == 0) begin
         m_bc = 0; m_phase = 1;
      end else if (m_bc == BLINK_DIV - 1) begin
         m_bc = 0; m_phase = 1 - m_phase;
      end else m_bc++;
      if (load) begin
         m_sign = int'(result_in[4]);
         m_mag  = int'(result_in[1:0]);
         m_err  = int'(divbyzero_in);
         m_zero = int'(zero_in);
      end
   endtask

   task automatic step(input logic r, input logic l, input logic [4:0] res,
                       input logic d, input logic z);
      rst = r; load = l; result_in = res; divbyzero_in = d; zero_in = z;
      @(posedge clk);
      model_edge();
      #1;
      check("seg", 32'(seg), 32'(exp_seg));
      check("an", 32'(an), 32'(exp_an));
      check("err_active", 32'(err_active), 32'(m_err));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      // reset and idle scan
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      idle(20);
      // "-3"
      step(1'b0, 1'b1, 5'b10011, 1'b0, 1'b0);
      idle(20);
      // negative zero shows "0"
      step(1'b0, 1'b1, 5'b10000, 1'b0, 1'b1);
      idle(20);
      // divide by zero, blinking Err
      step(1'b0, 1'b1, 5'b00000, 1'b1, 1'b0);
      idle(40);
      // ignored bits 3:2
      step(1'b0, 1'b1, 5'b01110, 1'b0, 1'b0);
      idle(20);
      // reset mid-blink, then load on a refresh wrap
      step(1'b0, 1'b1, 5'b10010, 1'b1, 1'b0);
      idle(12);
      step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      idle(5);
      for (int i = 0; i < 8 && m_rc != REFRESH_DIV - 1; i++) idle(1);
      check("wrap_align", 32'(m_rc), 32'(REFRESH_DIV - 1));
      step(1'b0, 1'b1, 5'b10001, 1'b0, 1'b0);
      idle(20);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 9) == 0),
              5'($urandom_range(0, 31)),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0));
      end
      idle(20);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
